// File: rtl/mips_soc_pkg.sv
// Shared definitions for the SoC peripherals: factorial FSM states and register map.
package mips_soc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fact_state_t;

  localparam logic [1:0] FACT_N      = 2'b00;
  localparam logic [1:0] FACT_GO     = 2'b01;
  localparam logic [1:0] FACT_STATUS = 2'b10;
  localparam logic [1:0] FACT_RESULT = 2'b11;

  localparam int unsigned FACT_N_MAX = 12;

endpackage

// File: rtl/mips_fact_unit_if.sv
// Word-addressed peripheral bus between the SoC decoder and the factorial unit.
interface mips_fact_unit_if;

  logic [1:0]  a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        done;
  logic        err;

  modport master (
    output a, we, wd,
    input  rd, done, err
  );

  modport slave (
    input  a, we, wd,
    output rd, done, err
  );

endinterface

// File: rtl/mips_fact_unit_fact_core.sv
// Iterative factorial engine: one acc*cnt multiply per cycle, result held until next completion.
module fact_core
  import mips_soc_pkg::*;
#(
  parameter int          N_W   = 4,
  parameter int unsigned N_MAX = FACT_N_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [31:0]    result
);

  fact_state_t    state;
  logic [31:0]    acc;
  logic [N_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done <= 1'b0;
            err  <= 1'b0;
            cnt  <= n;
            acc  <= 32'd1;
            // Out-of-range n would overflow 32 bits: finish immediately with an error.
            if (32'(n) > N_MAX) begin
              state  <= DONE;
              err    <= 1'b1;
              done   <= 1'b1;
              result <= '0;
            end else begin
              state <= BUSY;
              busy  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt > N_W'(1)) begin
            acc <= acc * 32'(cnt);
            cnt <= cnt - N_W'(1);
          end else begin
            result <= acc;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_fact_unit.sv
// Memory-mapped factorial accelerator: N register, GO decode and combinational read mux.
module mips_fact_unit
  import mips_soc_pkg::*;
#(
  parameter int          N_W   = 4,
  parameter int unsigned N_MAX = FACT_N_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_fact_unit_if.slave   bus
);

  logic [N_W-1:0] n_reg;
  logic           start;
  logic           busy;
  logic           done;
  logic           err;
  logic [31:0]    result;
  logic           wd_unused;

  assign wd_unused = ^bus.wd[31:N_W];
  assign start     = bus.we && (bus.a == FACT_GO) && bus.wd[0];

  // N stays writable while busy; the core latched its own copy at start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_reg <= '0;
    end else if (bus.we && (bus.a == FACT_N)) begin
      n_reg <= bus.wd[N_W-1:0];
    end
  end

  fact_core #(
    .N_W   (N_W),
    .N_MAX (N_MAX)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .n      (n_reg),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  always_comb begin
    bus.rd = '0;
    case (bus.a)
      FACT_N:      bus.rd = {{(32-N_W){1'b0}}, n_reg};
      FACT_GO:     bus.rd = {31'b0, busy};
      FACT_STATUS: bus.rd = {30'b0, err, done};
      FACT_RESULT: bus.rd = result;
      default:     bus.rd = '0;
    endcase
  end

  assign bus.done = done;
  assign bus.err  = err;

endmodule
